rf_scoreboard: RTL and testbench



---
 rtl/cpu_pkg.sv | 11 +
 rtl/rf_pend_counter.sv | 59 +++++
 rtl/rf_scoreboard.sv | 114 +++++++++++
 tb/tb_rf_scoreboard.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the CPU register file and scoreboard.
//   DATA_W   - default register width in bits
//   NUM_REGS - default number of architectural registers
//   CNT_W    - default width of each pending-write counter
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 4;
    localparam int CNT_W    = 2;

endpackage : cpu_pkg

// File: rtl/rf_pend_counter.sv
// rf_pend_counter: saturating up/down counter tracking in-flight writes to one
// register.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (counter -> 0)
//   inc         - reservation request; ignored while the counter is at max
//   dec         - writeback to this register; ignored while the counter is 0
//   busy        - counter is non-zero (taken straight from the flops)
//   full        - counter is at its maximum value
//   still_busy  - counter minus this cycle's accepted writeback is non-zero
module rf_pend_counter
    import cpu_pkg::*;
#(
    parameter int CNT_W_P = CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic full,
    output logic still_busy
);

    localparam logic [CNT_W_P-1:0] CNT_MAX  = {CNT_W_P{1'b1}};
    localparam logic [CNT_W_P-1:0] CNT_ZERO = {CNT_W_P{1'b0}};
    localparam logic [CNT_W_P-1:0] CNT_ONE  = CNT_W_P'(1'b1);

    logic [CNT_W_P-1:0] cnt_q;
    logic [CNT_W_P-1:0] cnt_d;
    logic               inc_eff_s;
    logic               dec_eff_s;

    // Saturating next-count: a reservation and a write in the same cycle cancel.
    always_comb begin
        inc_eff_s = inc && (cnt_q != CNT_MAX);
        dec_eff_s = dec && (cnt_q != CNT_ZERO);
        cnt_d     = cnt_q;
        case ({inc_eff_s, dec_eff_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Counter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy       = (cnt_q != CNT_ZERO);
    assign full       = (cnt_q == CNT_MAX);
    // A write landing this cycle is bypassed to readers, so it no longer blocks.
    assign still_busy = ((cnt_q - CNT_W_P'(dec_eff_s)) != CNT_ZERO);

endmodule : rf_pend_counter

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: parametrised register file with write-first bypass and a
// per-register pending-write scoreboard for RAW hazard detection.
// Ports:
//   clk, reset - clock, asynchronous active-high reset (clears all state)
//   rd_addr    - packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data    - packed combinational read data (bypassed from writeback)
//   rd_busy    - per port: addressed register still has an outstanding producer
//   wr_en, wr_addr, wr_data - writeback port
//   rsv_en, rsv_addr        - decode reservation of a destination register
//   rsv_full   - reservation target counter saturated; reservation dropped
//   busy_vec   - per register: pending-write counter non-zero (registered)
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_W_P   = DATA_W,
    parameter int NUM_REGS_P = NUM_REGS,
    parameter int ADDR_W     = $clog2(NUM_REGS_P),
    parameter int READ_PORTS = 2,
    parameter int CNT_W_P    = CNT_W,
    parameter bit ZERO_R0    = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [READ_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [READ_PORTS*DATA_W_P-1:0] rd_data,
    output logic [READ_PORTS-1:0]          rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W_P-1:0]            wr_data,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_addr,
    output logic                           rsv_full,
    output logic [NUM_REGS_P-1:0]          busy_vec
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [DATA_W_P-1:0]   regs_q [NUM_REGS_P];
    logic [DATA_W_P-1:0]   regs_d [NUM_REGS_P];
    logic [NUM_REGS_P-1:0] busy_s;
    logic [NUM_REGS_P-1:0] full_s;
    logic [NUM_REGS_P-1:0] still_busy_s;
    logic                  wr_ok_s;
    logic [ADDR_W-1:0]     ra_s;

    // Register 0 is hard-wired to zero when ZERO_R0 is set.
    assign wr_ok_s = wr_en && !(ZERO_R0 && (wr_addr == ADDR_ZERO));

    // Storage next-state: commit the writeback value.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok_s) begin
            regs_d[wr_addr] = wr_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS_P; r++) begin
                regs_q[r] <= {DATA_W_P{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // One pending-write counter per register; register 0 may be tied off.
    for (genvar r = 0; r < NUM_REGS_P; r++) begin : g_cnt
        if (ZERO_R0 && (r == 0)) begin : g_zero
            assign busy_s[r]       = 1'b0;
            assign full_s[r]       = 1'b0;
            assign still_busy_s[r] = 1'b0;
        end else begin : g_live
            rf_pend_counter #(
                .CNT_W_P (CNT_W_P)
            ) u_cnt (
                .clk        (clk),
                .reset      (reset),
                .inc        (rsv_en && (rsv_addr == ADDR_W'(r))),
                .dec        (wr_en && (wr_addr == ADDR_W'(r))),
                .busy       (busy_s[r]),
                .full       (full_s[r]),
                .still_busy (still_busy_s[r])
            );
        end
    end

    assign busy_vec = busy_s;
    assign rsv_full = !reset && rsv_en && full_s[rsv_addr];

    // Read ports: write-first bypass and hazard view, forced to 0 in reset.
    always_comb begin
        rd_data = {(READ_PORTS*DATA_W_P){1'b0}};
        rd_busy = {READ_PORTS{1'b0}};
        ra_s    = ADDR_ZERO;
        for (int p = 0; p < READ_PORTS; p++) begin
            ra_s = rd_addr[p*ADDR_W +: ADDR_W];
            if (reset) begin
                rd_data[p*DATA_W_P +: DATA_W_P] = {DATA_W_P{1'b0}};
                rd_busy[p]                      = 1'b0;
            end else if (wr_ok_s && (wr_addr == ra_s)) begin
                rd_data[p*DATA_W_P +: DATA_W_P] = wr_data;
                rd_busy[p]                      = still_busy_s[ra_s];
            end else begin
                rd_data[p*DATA_W_P +: DATA_W_P] = regs_q[ra_s];
                rd_busy[p]                      = still_busy_s[ra_s];
            end
        end
    end

endmodule : rf_scoreboard

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed self-checking bench for rf_scoreboard. Two
// instances share stimulus: one default, one with register 0 hard-wired.
module tb_rf_scoreboard;

    logic        clk;
    logic        reset;
    logic [3:0]  rd_addr;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [1:0]  rsv_addr;

    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        rsv_full;
    logic [3:0]  busy_vec;

    logic [31:0] rd_data_z;
    logic [1:0]  rd_busy_z;
    logic        rsv_full_z;
    logic [3:0]  busy_vec_z;

    int errors;
    int checks;

    rf_scoreboard u_dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_full (rsv_full),
        .busy_vec (busy_vec)
    );

    rf_scoreboard #(.ZERO_R0(1'b1)) u_dut_z (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_z),
        .rd_busy  (rd_busy_z),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_full (rsv_full_z),
        .busy_vec (busy_vec_z)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start a new cycle after the falling edge with all strobes idle.
    task automatic idle_cycle(input logic [1:0] a1, input logic [1:0] a0);
        @(negedge clk);
        wr_en   = 1'b0;
        rsv_en  = 1'b0;
        rd_addr = {a1, a0};
    endtask

    task automatic do_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        rsv_en  = 1'b0;
    endtask

    task automatic do_rsv(input logic [1:0] a);
        @(negedge clk);
        wr_en    = 1'b0;
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        rd_addr  = 4'h0;
        wr_en    = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 16'h0000;
        rsv_en   = 1'b0;
        rsv_addr = 2'd0;
        #12;
        check_eq("reset_rd_data", rd_data, 32'h0000_0000);
        check_eq("reset_busy_vec", {28'h0, busy_vec}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 1: reset mid-stream, between edges
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'hBEEF;
        rsv_en = 1'b1; rsv_addr = 2'd1;
        do_rsv(2'd1);
        idle_cycle(2'd1, 2'd2);
        #1;
        check_eq("t1_pre_data_r2", {16'h0, rd_data[15:0]}, 32'h0000_BEEF);
        check_eq("t1_pre_busy_vec", {28'h0, busy_vec}, 32'h2);
        check_eq("t1_pre_rd_busy", {30'h0, rd_busy}, 32'h2);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t1_rst_rd_data", rd_data, 32'h0000_0000);
        check_eq("t1_rst_busy_vec", {28'h0, busy_vec}, 32'h0);
        check_eq("t1_rst_rd_busy", {30'h0, rd_busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t1_post_r2_cleared", {16'h0, rd_data[15:0]}, 32'h0);

        // 2: write-first bypass on both ports
        do_write(2'd3, 16'h1111);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 16'hABCD; rd_addr = {2'd3, 2'd3};
        #1;
        check_eq("t2_bypass_both", rd_data, 32'hABCD_ABCD);
        idle_cycle(2'd3, 2'd3);
        #1;
        check_eq("t2_stored", rd_data, 32'hABCD_ABCD);

        // 3: RAW hazard on R1
        do_rsv(2'd1);
        idle_cycle(2'd1, 2'd1);
        #1;
        check_eq("t3_rd_busy", {31'h0, rd_busy[0]}, 32'h1);
        check_eq("t3_busy_vec1", {31'h0, busy_vec[1]}, 32'h1);
        idle_cycle(2'd1, 2'd1);
        do_write(2'd1, 16'h0042);
        #1;
        check_eq("t3_wr_rd_busy", {30'h0, rd_busy}, 32'h0);
        check_eq("t3_wr_rd_data", {16'h0, rd_data[15:0]}, 32'h0000_0042);
        idle_cycle(2'd1, 2'd1);
        #1;
        check_eq("t3_busy_vec1_clr", {31'h0, busy_vec[1]}, 32'h0);

        // 4: simultaneous reservation and write to R2 with cnt=1
        do_rsv(2'd2);
        @(negedge clk);
        rd_addr = {2'd2, 2'd2};
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h5555;
        rsv_en = 1'b1; rsv_addr = 2'd2;
        #1;
        check_eq("t4_rd_busy_same", {31'h0, rd_busy[0]}, 32'h0);
        check_eq("t4_rsv_full", {31'h0, rsv_full}, 32'h0);
        idle_cycle(2'd2, 2'd2);
        #1;
        check_eq("t4_busy_vec2", {31'h0, busy_vec[2]}, 32'h1);
        check_eq("t4_rd_busy_after", {31'h0, rd_busy[0]}, 32'h1);
        do_write(2'd2, 16'h6666);
        idle_cycle(2'd2, 2'd2);
        #1;
        check_eq("t4_busy_vec2_clr", {31'h0, busy_vec[2]}, 32'h0);

        // 5: saturation on R3
        for (int i = 0; i < 3; i++) begin
            do_rsv(2'd3);
            #1;
            check_eq("t5_rsv_not_full", {31'h0, rsv_full}, 32'h0);
        end
        do_rsv(2'd3);
        #1;
        check_eq("t5_rsv_full", {31'h0, rsv_full}, 32'h1);
        idle_cycle(2'd3, 2'd3);
        #1;
        check_eq("t5_busy_sat", {31'h0, busy_vec[3]}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            do_write(2'd3, 16'h7000 + 16'(i));
            idle_cycle(2'd3, 2'd3);
            #1;
            check_eq("t5_busy_drain", {31'h0, busy_vec[3]}, (i < 2) ? 32'h1 : 32'h0);
        end
        do_write(2'd3, 16'h7777);
        idle_cycle(2'd3, 2'd3);
        #1;
        check_eq("t5_extra_wr_data", {16'h0, rd_data[15:0]}, 32'h0000_7777);
        check_eq("t5_extra_wr_busy", {28'h0, busy_vec}, 32'h0);

        // 6: hard-wired register 0 (second instance), default instance for contrast
        @(negedge clk);
        rd_addr = {2'd0, 2'd0};
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hFFFF;
        rsv_en = 1'b1; rsv_addr = 2'd0;
        #1;
        check_eq("t6_z_bypass", {16'h0, rd_data_z[15:0]}, 32'h0);
        check_eq("t6_z_rsv_full", {31'h0, rsv_full_z}, 32'h0);
        check_eq("t6_dflt_bypass", {16'h0, rd_data[15:0]}, 32'h0000_FFFF);
        idle_cycle(2'd0, 2'd0);
        #1;
        check_eq("t6_z_rd_data", {16'h0, rd_data_z[15:0]}, 32'h0);
        check_eq("t6_z_rd_busy", {30'h0, rd_busy_z}, 32'h0);
        check_eq("t6_z_busy_vec0", {31'h0, busy_vec_z[0]}, 32'h0);
        check_eq("t6_dflt_busy_vec0", {31'h0, busy_vec[0]}, 32'h1);
        check_eq("t6_dflt_rd_data", {16'h0, rd_data[15:0]}, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rf_scoreboard
